ook_frame_decoder: RTL and testbench
====================================

# ook_frame_decoder

Receive-side counterpart of the OOK packet transmit path. Takes the demodulated digital output of a 350 MHz ASK receiver front-end and decodes pulse-width-encoded fan-remote frames into a payload word. Runs in the 10 MHz domain and hands each decoded frame to downstream logic (LED status, UART reporting) as a one-cycle strobe.

## Interface
- `SYM_CYCLES`, default 5000: nominal bit symbol length in clk cycles (500 µs at 10 MHz).
- `SYNC_MIN`, default 20000: minimum high time in cycles that qualifies as a sync pulse.
- `PAYLOAD_BITS`, default 32: data bits per frame.
- `GLITCH_CYCLES`, default 8: input stability required before a level change is accepted.
- `REPEAT_WINDOW`, default 200000: maximum cycles between frame ends for the repeat check.
- `CNT_W`, default 20: width of the saturating pulse counter.
- `clk`, in, 1: 10 MHz clock.
- `reset`, in, 1: **synchronous, active-high** reset.
- `ook_in`, in, 1: asynchronous demodulated OOK input.
- `frame_data`, out, PAYLOAD_BITS: last accepted payload, MSB first as received.
- `frame_valid`, out, 1: one-cycle strobe; `frame_data` updated on the same edge.
- `frame_err`, out, 1: one-cycle strobe on aborted frame.
- `busy`, out, 1: high in any state other than HUNT.

## Operation
- Input path: 2-FF synchronizer, then glitch filter. Filtered level `lvl` changes only after the synchronized input has differed from `lvl` for GLITCH_CYCLES consecutive cycles. Edges are detected on `lvl`.
- The counter clears on every `lvl` edge and increments otherwise. It saturates at 2^CNT_W-1 and does not wrap.
- States:
  - HUNT: on a rising edge, go to SYNC.
  - SYNC: on a falling edge with count ≥ SYNC_MIN, set bit_idx=0 and go to GAP. Any shorter pulse returns silently to HUNT, with no `frame_err`.
  - GAP (low): on a rising edge, go to BIT. If the low count exceeds 2·SYM_CYCLES, raise `frame_err` and go to HUNT.
  - BIT (high): on a falling edge, classify the high time h:
    - SYM_CYCLES/8 ≤ h < SYM_CYCLES/2: bit 0.
    - SYM_CYCLES/2 ≤ h ≤ 7·SYM_CYCLES/8: bit 1.
    - Otherwise: raise `frame_err` and go to HUNT.
    - On a valid bit, shift it into the shift register LSB. If bit_idx = PAYLOAD_BITS-1, emit the frame and go to HUNT; otherwise increment bit_idx and go to GAP.
- Emit: copy the shift register to `frame_data` and pulse `frame_valid`.
- `frame_err` and `frame_valid` are never asserted together.
- A sync-length pulse seen in BIT is an invalid bit: raise `frame_err`, go to HUNT. That falling edge is not reused as a sync.
- Reset, including mid-frame: state HUNT, counter 0, bit_idx 0, shift register 0, `frame_data` 0, `frame_valid`/`frame_err`/`busy` 0, synchronizer and filter at 0. Any partial frame is discarded.

## Timing
- Pin-to-`lvl` latency: 2 + GLITCH_CYCLES cycles.
- `frame_valid` is registered and asserts on the clock after `lvl` falls for the last bit.
- Strobes are exactly 1 cycle wide.
- Back-to-back frames are supported: HUNT is re-entered on the emit cycle.

## Configuration
- `OOK_DECODER_REPEAT_CHECK_EN` defined:
  - A frame decoded as in Operation is a candidate. `frame_valid` pulses only if the candidate equals the previous candidate and the previous candidate ended ≤ REPEAT_WINDOW cycles earlier. `frame_data` updates only on that pulse.
  - The previous candidate and its age counter (saturating) are always updated on each candidate. They are cleared by reset.
  - `frame_err` is unaffected.
- Not defined: every decoded frame pulses `frame_valid`, and no repeat logic is synthesized.

## Structure
- Shared package `ook_pkg`:
  - state enum (HUNT, SYNC, GAP, BIT)
  - default constants for SYM_CYCLES, SYNC_MIN, PAYLOAD_BITS, shared with `packet_generator`, so the encoder and decoder timing come from one source.
- Sub-module `ook_glitch_filter`: synchronizer plus stability counter, parameterized by GLITCH_CYCLES.

## Test plan
- Reset, then idle low for 10000 cycles → `frame_valid`=0, `frame_err`=0, `busy`=0, `frame_data`=0.
- 25000-cycle sync, then 32 bits of 0xA5C3_0F17 (bit 0 = 1500 high/3500 low, bit 1 = 3500 high/1500 low) → one `frame_valid`, `frame_data`=0xA5C30F17, no `frame_err`.
- Valid frame with 3-cycle low glitches injected into the high pulses → identical decode, 0xA5C30F17.
- Sync followed by a 12000-cycle low gap → one `frame_err`, state HUNT, `frame_data` unchanged.
- Reset asserted after bit 10 of a frame, then a full frame sent → only the second frame is reported.
- `OOK_DECODER_REPEAT_CHECK_EN`, three identical frames 158400 cycles apart → `frame_valid` on frames 2 and 3 only. With 300000-cycle spacing → no `frame_valid`.

Source files
------------

// File: rtl/ook_pkg.sv
// Shared OOK timing defaults and decoder state encoding. packet_generator and
// ook_frame_decoder both take their symbol timing from these constants.
package ook_pkg;

    localparam int SYM_CYCLES_DEF   = 5000;   // 500 us at 10 MHz
    localparam int SYNC_MIN_DEF     = 20000;
    localparam int PAYLOAD_BITS_DEF = 32;

    typedef enum logic [1:0] {
        HUNT,
        SYNC,
        GAP,
        BIT
    } state_t;

endpackage

// File: rtl/ook_frame_decoder_if.sv
// Decoder bus: demodulated input in, decoded frame strobes out, plus FSM state for observation.
// Strobes carry no ready: the decoder cannot be stalled, so a receiver must sample on the strobe cycle.
interface ook_frame_decoder_if
    import ook_pkg::*;
#(
    parameter int PAYLOAD_BITS = PAYLOAD_BITS_DEF
);

    logic                    ook_in;
    logic [PAYLOAD_BITS-1:0] frame_data;
    logic                    frame_valid;
    logic                    frame_err;
    logic                    busy;
    state_t                  state;

    modport master (
        output ook_in,
        input  frame_data,
        input  frame_valid,
        input  frame_err,
        input  busy,
        input  state
    );

    modport slave (
        input  ook_in,
        output frame_data,
        output frame_valid,
        output frame_err,
        output busy,
        output state
    );

endinterface

// File: rtl/ook_glitch_filter.sv
// Two-flop synchronizer followed by a stability filter: lvl follows the input only after
// it has disagreed with lvl for GLITCH_CYCLES consecutive cycles.
module ook_glitch_filter #(
    parameter int GLITCH_CYCLES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic lvl
);

    localparam int GW = (GLITCH_CYCLES > 1) ? $clog2(GLITCH_CYCLES) : 1;
    localparam logic [GW-1:0] STABLE_LAST = GW'(GLITCH_CYCLES - 1);

    logic          sync0;
    logic          sync1;
    logic [GW-1:0] stable_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync0      <= 1'b0;
            sync1      <= 1'b0;
            lvl        <= 1'b0;
            stable_cnt <= '0;
        end else begin
            sync0 <= din;
            sync1 <= sync0;
            // Any sample agreeing with lvl restarts the stability run.
            if (sync1 != lvl) begin
                if (stable_cnt == STABLE_LAST) begin
                    lvl        <= sync1;
                    stable_cnt <= '0;
                end else begin
                    stable_cnt <= stable_cnt + 1'b1;
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ook_frame_decoder.sv
// OOK pulse-width frame decoder: sync pulse, then PAYLOAD_BITS high-time coded bits, MSB first.
// Define OOK_DECODER_REPEAT_CHECK_EN to report only frames repeated within REPEAT_WINDOW cycles.
module ook_frame_decoder
    import ook_pkg::*;
#(
    parameter int SYM_CYCLES    = SYM_CYCLES_DEF,
    parameter int SYNC_MIN      = SYNC_MIN_DEF,
    parameter int PAYLOAD_BITS  = PAYLOAD_BITS_DEF,
    parameter int GLITCH_CYCLES = 8,
    parameter int REPEAT_WINDOW = 200000,
    parameter int CNT_W         = 20
) (
    input logic                clk,
    input logic                reset,
    ook_frame_decoder_if.slave bus
);

    localparam int LW    = CNT_W + 1;
    localparam int IDX_W = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;
    localparam logic [CNT_W:0] SYNC_LEN = LW'(SYNC_MIN);
    localparam logic [CNT_W:0] B0_MIN   = LW'(SYM_CYCLES / 8);
    localparam logic [CNT_W:0] B1_MIN   = LW'(SYM_CYCLES / 2);
    localparam logic [CNT_W:0] B1_MAX   = LW'((7 * SYM_CYCLES) / 8);
    localparam logic [CNT_W:0] GAP_MAX  = LW'(2 * SYM_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAYLOAD_BITS - 1);

    logic                    lvl;
    logic                    lvl_d;
    logic                    rise;
    logic                    fall;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W:0]          len;
    state_t                  state;
    state_t                  next_state;
    logic [IDX_W-1:0]        bit_idx;
    logic [PAYLOAD_BITS-1:0] shreg;
    logic [PAYLOAD_BITS-1:0] shifted;
    logic                    start;
    logic                    shift_en;
    logic                    bit_val;
    logic                    emit;
    logic                    err;
    logic                    accept;

    ook_glitch_filter #(.GLITCH_CYCLES(GLITCH_CYCLES)) u_filter (
        .clk   (clk),
        .reset (reset),
        .din   (bus.ook_in),
        .lvl   (lvl)
    );

    assign rise    = lvl & ~lvl_d;
    assign fall    = ~lvl & lvl_d;
    // cnt restarts one cycle after an edge, so the level's duration is cnt + 1.
    assign len     = {1'b0, cnt} + LW'(1);
    assign shifted = {shreg[PAYLOAD_BITS-2:0], bit_val};

    always_ff @(posedge clk) begin
        if (reset) state <= HUNT;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        start      = 1'b0;
        shift_en   = 1'b0;
        bit_val    = 1'b0;
        emit       = 1'b0;
        err        = 1'b0;
        case (state)
            HUNT: if (rise) next_state = SYNC;
            SYNC: if (fall) begin
                if (len >= SYNC_LEN) begin
                    start      = 1'b1;
                    next_state = GAP;
                end else begin
                    next_state = HUNT;
                end
            end
            GAP: begin
                if (rise) begin
                    next_state = BIT;
                end else if (len > GAP_MAX) begin
                    err        = 1'b1;
                    next_state = HUNT;
                end
            end
            BIT: if (fall) begin
                if (len >= B0_MIN && len < B1_MIN) begin
                    shift_en = 1'b1;
                end else if (len >= B1_MIN && len <= B1_MAX) begin
                    shift_en = 1'b1;
                    bit_val  = 1'b1;
                end else begin
                    err        = 1'b1;
                    next_state = HUNT;
                end
                if (shift_en) begin
                    emit       = (bit_idx == IDX_LAST);
                    next_state = emit ? HUNT : GAP;
                end
            end
            default: next_state = HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lvl_d           <= 1'b0;
            cnt             <= '0;
            bit_idx         <= '0;
            shreg           <= '0;
            bus.frame_data  <= '0;
            bus.frame_valid <= 1'b0;
            bus.frame_err   <= 1'b0;
        end else begin
            lvl_d <= lvl;
            if (rise || fall)   cnt <= '0;
            else if (cnt != '1) cnt <= cnt + 1'b1;
            if (start)                 bit_idx <= '0;
            else if (shift_en && !emit) bit_idx <= bit_idx + 1'b1;
            if (shift_en) shreg <= shifted;
            bus.frame_valid <= accept;
            bus.frame_err   <= err;
            if (accept) bus.frame_data <= shifted;
        end
    end

`ifdef OOK_DECODER_REPEAT_CHECK_EN
    localparam int AGE_W = $clog2(REPEAT_WINDOW + 2);
    localparam logic [AGE_W:0] WINDOW = (AGE_W + 1)'(REPEAT_WINDOW);

    logic [PAYLOAD_BITS-1:0] prev_cand;
    logic                    prev_ok;
    logic [AGE_W-1:0]        age;

    // age holds (cycles since the previous candidate) - 1, so "<= WINDOW cycles" is age < WINDOW.
    assign accept = emit && prev_ok && (prev_cand == shifted) && ({1'b0, age} < WINDOW);

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_cand <= '0;
            prev_ok   <= 1'b0;
            age       <= '0;
        end else if (emit) begin
            prev_cand <= shifted;
            prev_ok   <= 1'b1;
            age       <= '0;
        end else if (age != '1) begin
            age <= age + 1'b1;
        end
    end
`else
    assign accept = emit;
`endif

    assign bus.busy  = (state != HUNT);
    assign bus.state = state;

endmodule

// File: tb/tb_ook_frame_decoder.sv
// Scoreboarded bench for ook_frame_decoder: pulse-list reference model, randomized frames and errors.
module tb_ook_frame_decoder;
    import ook_pkg::*;

    localparam int SYM  = 48;
    localparam int SYNC = 192;
    localparam int PB   = 32;
    localparam int GL   = 4;
    localparam int RW   = 4000;
    localparam int CW   = 12;
    localparam logic [PB-1:0] GOLD = 32'hA5C3_0F17;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ook_frame_decoder_if #(.PAYLOAD_BITS(PB)) bus ();

    ook_frame_decoder #(
        .SYM_CYCLES    (SYM),
        .SYNC_MIN      (SYNC),
        .PAYLOAD_BITS  (PB),
        .GLITCH_CYCLES (GL),
        .REPEAT_WINDOW (RW),
        .CNT_W         (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int            tests = 0;
    int            fails = 0;
    longint        cyc   = 0;
    logic [PB-1:0] exp_q[$];
    logic [PB-1:0] err_q[$];
    logic [PB-1:0] last_data = '0;
    int            hi_a[PB];
    int            lo_a[PB];
    bit            prev_valid = 1'b0;
`ifdef OOK_DECODER_REPEAT_CHECK_EN
    bit            have_prev = 1'b0;
    logic [PB-1:0] prev_data = '0;
    longint        prev_t    = 0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model_accept(input logic [PB-1:0] d, input longint t);
        bit ok;
        ok = 1'b1;
`ifdef OOK_DECODER_REPEAT_CHECK_EN
        ok = have_prev && (d == prev_data) && ((t - prev_t) <= RW);
        have_prev = 1'b1;
        prev_data = d;
        prev_t    = t;
`endif
        if (ok) begin
            exp_q.push_back(d);
            last_data = d;
        end
    endtask

    // Walks the pulse list: gaps over 2*SYM or highs outside the bit windows abort the frame.
    task automatic model_issue(input int sync_len, input int lead, input int n);
        logic [PB-1:0] d;
        int            gap;
        longint        t;
        d   = '0;
        gap = lead;
        t   = cyc + sync_len + lead;
        if (sync_len < SYNC) return;
        for (int i = 0; i < n; i++) begin
            if (gap > 2 * SYM) begin
                err_q.push_back(last_data);
                return;
            end
            if (hi_a[i] >= SYM / 8 && hi_a[i] < SYM / 2)              d = {d[PB-2:0], 1'b0};
            else if (hi_a[i] >= SYM / 2 && hi_a[i] <= (7 * SYM) / 8) d = {d[PB-2:0], 1'b1};
            else begin
                err_q.push_back(last_data);
                return;
            end
            t += hi_a[i];
            if (i == PB - 1) begin
                model_accept(d, t);
                return;
            end
            t  += lo_a[i];
            gap = lo_a[i];
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input int n);
        bus.ook_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_high(input int n, input bit glitch);
        int pos;
        if (glitch && n >= 14) begin
            pos = $urandom_range(5, n - 8);
            drive(1'b1, pos);
            drive(1'b0, 3);
            drive(1'b1, n - pos - 3);
        end else begin
            drive(1'b1, n);
        end
    endtask

    task automatic fill_std(input logic [PB-1:0] d);
        for (int i = 0; i < PB; i++) begin
            hi_a[i] = d[PB-1-i] ? 34 : 14;
            lo_a[i] = d[PB-1-i] ? 14 : 34;
        end
    endtask

    task automatic fill_rand(input logic [PB-1:0] d);
        for (int i = 0; i < PB; i++) begin
            hi_a[i] = d[PB-1-i] ? $urandom_range(26, 40) : $urandom_range(8, 22);
            lo_a[i] = $urandom_range(10, 70);
        end
    endtask

    task automatic fill_edge(input logic [PB-1:0] d);
        for (int i = 0; i < PB; i++) begin
            if (d[PB-1-i]) hi_a[i] = ($urandom_range(0, 1) == 1) ? 24 : 42;
            else           hi_a[i] = ($urandom_range(0, 1) == 1) ? 6 : 23;
            lo_a[i] = 24;
        end
    endtask

    task automatic send_frame(input int sync_len, input int lead, input int n, input bit glitch);
        model_issue(sync_len, lead, n);
        drive_high(sync_len, glitch);
        drive(1'b0, lead);
        for (int i = 0; i < n; i++) begin
            drive_high(hi_a[i], glitch);
            drive(1'b0, lo_a[i]);
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        bus.ook_in = 1'b0;
        repeat (4) @(negedge clk);
        reset     = 1'b0;
        last_data = '0;
`ifdef OOK_DECODER_REPEAT_CHECK_EN
        have_prev = 1'b0;
`endif
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, bus.frame_valid, 0);
        check({tag, "_err"},   bus.frame_err, 0);
        check({tag, "_busy"},  bus.busy, 0);
        check({tag, "_data"},  bus.frame_data, 0);
        check({tag, "_state"}, bus.state, HUNT);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.frame_valid && bus.frame_err) begin
                tests++;
                fails++;
                $display("FAIL strobe_overlap: valid=1 err=1, required never both");
            end
            if (bus.frame_valid) begin
                check("valid_width", prev_valid, 0);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_valid: data %0h, required no strobe", bus.frame_data);
                end else begin
                    check("frame_data", bus.frame_data, exp_q.pop_front());
                end
            end
            if (bus.frame_err) begin
                if (err_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_err: state %0d, required no strobe", bus.state);
                end else begin
                    check("err_keeps_data", bus.frame_data, err_q.pop_front());
                    check("err_state_hunt", bus.state, HUNT);
                end
            end
            prev_valid = bus.frame_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [PB-1:0] d;
        int            kind;
        int            j;
        longint        t0;
        int            spacing;

        bus.ook_in = 1'b0;
        @(negedge clk);
        do_reset();
        drive(1'b0, 500);
        check_idle("reset");

        fill_std(GOLD);
        send_frame(240, 34, PB, 1'b0);
        drive(1'b0, 60);
        fill_std(GOLD);
        send_frame(240, 34, PB, 1'b1);
        drive(1'b0, 60);

        fill_std(32'h1234_5678);
        send_frame(240, 130, PB, 1'b0);
        drive(1'b0, 60);
        check("gap_err_state", bus.state, HUNT);
        check("gap_err_data", bus.frame_data, last_data);

        d = $urandom;
        fill_edge(d);
        send_frame(SYNC, 34, PB, 1'b0);
        drive(1'b0, 60);
        fill_std(d);
        send_frame(SYNC - 1, 34, PB, 1'b0);
        drive(1'b0, 60);
        fill_std(d);
        hi_a[7] = 5;
        send_frame(240, 34, PB, 1'b0);
        drive(1'b0, 60);
        fill_std(d);
        hi_a[20] = 43;
        send_frame(240, 34, PB, 1'b0);
        drive(1'b0, 60);
        fill_std(d);
        hi_a[3] = 230;
        send_frame(240, 34, PB, 1'b0);
        drive(1'b0, 60);

        fill_std(32'hDEAD_BEEF);
        send_frame(240, 34, 11, 1'b0);
        check("midframe_busy", bus.busy, 1);
        do_reset();
        check_idle("midreset");
        fill_std(32'hDEAD_BEEF);
        send_frame(240, 34, PB, 1'b0);
        drive(1'b0, 60);

        for (int f = 0; f < 10; f++) begin
            d    = $urandom;
            kind = $urandom_range(0, 3);
            j    = $urandom_range(0, PB - 2);
            fill_rand(d);
            case (kind)
                1: hi_a[j] = ($urandom_range(0, 1) == 1) ? $urandom_range(4, 5) : $urandom_range(46, 60);
                2: lo_a[j] = $urandom_range(110, 150);
                3: hi_a[j] = $urandom_range(200, 260);
                default: ;
            endcase
            send_frame($urandom_range(200, 280), $urandom_range(10, 70), PB, $urandom_range(0, 1) == 1);
            drive(1'b0, $urandom_range(20, 80));
        end

`ifdef OOK_DECODER_REPEAT_CHECK_EN
        for (int s = 0; s < 2; s++) begin
            spacing = (s == 0) ? 3168 : 6000;
            d       = (s == 0) ? 32'h5A5A_3C3C : 32'hC3C3_5A5A;
            for (int k = 0; k < 3; k++) begin
                t0 = cyc;
                fill_std(d);
                send_frame(240, 34, PB, 1'b0);
                drive(1'b0, spacing - int'(cyc - t0));
            end
        end
`endif

        for (int k = 0; k < 400 && (exp_q.size() != 0 || err_q.size() != 0); k++) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);
        check("err_q_drained", err_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
